// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Brings a clock domain out of reset behind a PLL. The raw lock is first
// synchronized. It must then stay high for a qualification window. After that,
// sys_reset is held for a fixed number of cycles before the domain runs.
// Losing lock at any point sends the block back to waiting. Lock losses seen
// while running are counted, and the count saturates.
module pll_reset_sequencer #(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int RESET_HOLD_CYCLES  = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       lock,
   input  logic       soft_rst,
   output logic       sys_reset,
   output logic       ready,
   output logic [1:0] state,
   output logic [7:0] lock_lost_count
);

   // One counter serves both the qualification window and the reset hold.
   localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                            LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
   localparam logic [1:0] ST_STABILIZE = 2'd1;
   localparam logic [1:0] ST_HOLD      = 2'd2;
   localparam logic [1:0] ST_RUN       = 2'd3;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lock_sync;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [7:0]       lost_q,  lost_d;

   // Lock synchronizer: a plain flop chain with no logic between the stages.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         // NOTE: non-blocking assignment keeps each stage sampling the
         // pre-edge value of the previous one; blocking would collapse the chain.
         sync_q <= {sync_q[SYNC_STAGES-2:0], lock};
      end
   end

   assign lock_sync = sync_q[SYNC_STAGES-1];

   // Next-state logic. A lock loss always wins over soft_rst.
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves one
      // unassigned and no latch is inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      lost_d  = lost_q;

      case (state_q)
         ST_WAIT_LOCK: begin
            if (lock_sync) begin
               state_d = ST_STABILIZE;
               cnt_d   = '0;
            end
         end

         ST_STABILIZE: begin
            if (!lock_sync) begin
               state_d = ST_WAIT_LOCK;
            end else if (cnt_q == STAB_LAST) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         ST_HOLD: begin
            if (!lock_sync) begin
               state_d = ST_WAIT_LOCK;
            end else if (soft_rst) begin
               cnt_d = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         ST_RUN: begin
            if (!lock_sync) begin
               state_d = ST_WAIT_LOCK;
               if (lost_q != 8'hFF) begin
                  lost_d = lost_q + 8'd1;
               end
            end else if (soft_rst) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = ST_WAIT_LOCK;
         end
      endcase
   end

   // State, counter and lock-loss counter registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_WAIT_LOCK;
         cnt_q   <= '0;
         lost_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lost_q  <= lost_d;
      end
   end

   // The outputs are decoded from the state register only, so no input
   // reaches sys_reset or ready combinationally.
   assign sys_reset       = (state_q != ST_RUN);
   assign ready           = (state_q == ST_RUN);
   assign state           = state_q;
   assign lock_lost_count = lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
// The scoreboard works as follows. Every posedge, a timeline-based reference
// model pushes the expected outputs into a queue. A monitor pops that queue on
// each negedge and compares it with the DUT outputs. Directed scenarios add
// latency, priority and saturation checks on top, and randomized lock and
// soft_rst traffic follows them.
module tb_pll_reset_sequencer;

   localparam int S = 2;
   localparam int L = 8;
   localparam int H = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       lock;
   logic       soft_rst;
   logic       sys_reset;
   logic       ready;
   logic [1:0] state;
   logic [7:0] lock_lost_count;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [1:0] st;
      logic       srst;
      logic       rdy;
      logic [7:0] lost;
   } exp_t;

   exp_t exp_q[$];

   // Reference model. The block either waits for lock, or it sits on a
   // timeline. On that timeline, stabilizing lasts until edge m_hold_start,
   // holding lasts H more edges, and running follows. soft_rst restarts the
   // hold at the current edge.
   bit   m_in_wait    = 1'b1;
   int   m_edge       = 0;
   int   m_hold_start = 0;
   int   m_lost       = 0;
   int   m_state      = 0;
   logic m_hist[$];

   pll_reset_sequencer #(
      .SYNC_STAGES       (S),
      .LOCK_STABLE_CYCLES(L),
      .RESET_HOLD_CYCLES (H)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .lock           (lock),
      .soft_rst       (soft_rst),
      .sys_reset      (sys_reset),
      .ready          (ready),
      .state          (state),
      .lock_lost_count(lock_lost_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_state(input int e);
      if (m_in_wait)               return 0;
      if (e < m_hold_start)        return 1;
      if (e < m_hold_start + H)    return 2;
      return 3;
   endfunction

   task automatic model_reset();
      m_in_wait    = 1'b1;
      m_edge       = 0;
      m_hold_start = 0;
      m_lost       = 0;
      m_state      = 0;
      m_hist.delete();
   endtask

   task automatic model_step(input logic lk, input logic sr);
      logic ls;
      int   prev;
      // The FSM sees lock as it was sampled S edges earlier (zero after reset).
      ls = (m_hist.size() == S) ? m_hist[0] : 1'b0;
      m_hist.push_back(lk);
      if (m_hist.size() > S) m_hist.delete(0);

      prev = model_state(m_edge - 1);
      if (!ls) begin
         if (prev == 3 && m_lost < 255) m_lost++;
         m_in_wait = 1'b1;
      end else if (m_in_wait) begin
         m_in_wait    = 1'b0;
         m_hold_start = m_edge + L;
      end else if (sr && prev >= 2) begin
         m_hold_start = m_edge;
      end
      m_state = model_state(m_edge);
      m_edge++;
   endtask

   // Model process: one expected entry per clock edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         if (reset) model_reset();
         else       model_step(lock, soft_rst);
         e.st   = 2'(m_state);
         e.srst = (m_state != 3);
         e.rdy  = (m_state == 3);
         e.lost = 8'(m_lost);
         exp_q.push_back(e);
      end
   end

   // Monitor: compare the DUT against the oldest expected entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_ctrl", {state, sys_reset, ready}, {e.st, e.srst, e.rdy});
            check("sb_lost", lock_lost_count, e.lost);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   task automatic wait_state(input logic [1:0] s, input string name);
      int n = 0;
      while (state !== s && n < 200) begin
         @(negedge clock);
         n++;
      end
      check({"reach_", name}, 32'(state === s), 32'd1);
   endtask

   // Count the edges after the first one until sys_reset reaches the level.
   task automatic edges_until(input logic level, output int n, output logic [3:0] seen);
      n    = 0;
      seen = '0;
      forever begin
         @(posedge clock);
         #1;
         seen[state] = 1'b1;
         if (sys_reset === level || n >= 200) break;
         n++;
      end
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      #2 reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      int         n;
      int         dur;
      logic [3:0] seen;

      reset    = 1'b1;
      lock     = 1'b1;
      soft_rst = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_ctrl", {state, sys_reset, ready}, {2'd0, 1'b1, 1'b0});
      check("rst_lost", lock_lost_count, 32'd0);

      // Release with lock high: run after S+L+H edges.
      reset = 1'b0;
      edges_until(1'b0, n, seen);
      check("release_edges", n, S + L + H);
      check("release_states", seen, 32'hF);
      check("release_ready", ready, 32'd1);
      check("release_lost", lock_lost_count, 32'd0);

      // One-cycle lock glitch while stabilizing at cnt=5.
      pulse_reset();
      wait_state(2'd1, "stab");
      repeat (5) @(negedge clock);
      check("glitch_in_stab", state, 32'd1);
      lock = 1'b0;
      @(negedge clock);
      lock = 1'b1;
      edges_until(1'b0, n, seen);
      check("glitch_release_edges", n, S + L + H);
      check("glitch_saw_wait", seen[0], 32'd1);
      check("glitch_lost", lock_lost_count, 32'd0);

      // Lock loss in RUN, then saturation of the loss counter.
      @(negedge clock);
      lock = 1'b0;
      edges_until(1'b1, n, seen);
      check("loss_edges", n, S);
      check("loss_state", state, 32'd0);
      check("loss_lost", lock_lost_count, 32'd1);
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         lock = 1'b1;
         wait_state(2'd3, "loop_run");
         lock = 1'b0;
         wait_state(2'd0, "loop_wait");
      end
      check("sat_lost", lock_lost_count, 32'd255);

      // Build up a count of 3, then soft reset from RUN.
      lock = 1'b1;
      pulse_reset();
      for (int i = 0; i < 3; i++) begin
         wait_state(2'd3, "build_run");
         lock = 1'b0;
         wait_state(2'd0, "build_wait");
         lock = 1'b1;
      end
      wait_state(2'd3, "pre_soft");
      check("pre_soft_lost", lock_lost_count, 32'd3);
      soft_rst = 1'b1;
      @(negedge clock);
      soft_rst = 1'b0;
      check("soft_state", state, 32'd2);
      n = 0;
      while (sys_reset && n < 50) begin
         n++;
         @(negedge clock);
      end
      check("soft_hold_cycles", n, H);
      check("soft_back_run", state, 32'd3);
      check("soft_lost", lock_lost_count, 32'd3);

      // Asynchronous reset in the middle of HOLD.
      soft_rst = 1'b1;
      @(negedge clock);
      soft_rst = 1'b0;
      check("hold_before_rst", state, 32'd2);
      #2 reset = 1'b1;
      #1;
      check("async_ctrl", {state, sys_reset, ready}, {2'd0, 1'b1, 1'b0});
      check("async_lost", lock_lost_count, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // soft_rst in the same cycle that lock_sync falls in RUN.
      wait_state(2'd3, "run_prio");
      lock = 1'b0;
      repeat (S) @(negedge clock);
      soft_rst = 1'b1;
      @(negedge clock);
      soft_rst = 1'b0;
      check("prio_state", state, 32'd0);
      check("prio_lost", lock_lost_count, 32'd1);

      // Randomized lock and soft_rst traffic with occasional async resets.
      lock = 1'b1;
      dur  = 20;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         soft_rst = ($urandom_range(0, 7) == 0);
         dur = dur - 1;
         if (dur == 0) begin
            lock = ~lock;
            dur  = lock ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 6));
         end
         if ($urandom_range(0, 599) == 0) begin
            #2 reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
         end
      end

      soft_rst = 1'b0;
      repeat (3) @(negedge clock);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
